prefix_window_builder: RTL

- Decode-front block that produces the prefix and opcode-window fields consumed by the control-store overwrite logic: isREP, isSIZE, isSEG, segSEL, prefSize, B1/B2/B3 and isDouble.
- Takes a byte-serial instruction stream from the fetch aligner (valid/ready).
- Strips and classifies x86 legacy prefixes, then captures the next three bytes as the opcode/ModRM window.
- Emits one registered packet per instruction to decode (valid/ready).

---
 rtl/prefix_window_builder_if.sv | 32 +++
 rtl/prefix_window_builder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/prefix_window_builder_if.sv
// Byte stream in from the fetch aligner and prefix/opcode-window packet out to decode.
// The master drives bytes and accepts packets; the slave is the window builder.
interface prefix_window_builder_if;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       isREP;
    logic       isREPNE;
    logic       isSIZE;
    logic       isSEG;
    logic [5:0] segSEL;
    logic [3:0] prefSize;
    logic       pref_err;
    logic       isDouble;
    logic [7:0] B1;
    logic [7:0] B2;
    logic [7:0] B3;

    modport master (
        output in_byte, in_valid, out_ready,
        input  in_ready, out_valid, isREP, isREPNE, isSIZE, isSEG, segSEL,
               prefSize, pref_err, isDouble, B1, B2, B3
    );

    modport slave (
        input  in_byte, in_valid, out_ready,
        output in_ready, out_valid, isREP, isREPNE, isSIZE, isSEG, segSEL,
               prefSize, pref_err, isDouble, B1, B2, B3
    );
endinterface

// File: rtl/prefix_window_builder.sv
// Strips x86 legacy prefixes and captures the 3-byte opcode window; packet is valid 1 cycle after B3.
// Stalls input while a packet is held unaccepted; the handoff cycle may already consume the next byte.
module prefix_window_builder #(
    parameter int MAX_PREF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    prefix_window_builder_if.slave bus
);

    typedef enum logic [1:0] {
        PREF = 2'd0,
        GET2 = 2'd1,
        GET3 = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_PREF);

    function automatic logic is_prefix(input logic [7:0] b);
        case (b)
            8'hF3, 8'hF2, 8'h66, 8'hF0,
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    function automatic logic [5:0] seg_code(input logic [7:0] b);
        case (b)
            8'h2E:   return 6'b000001;
            8'h36:   return 6'b000010;
            8'h3E:   return 6'b000100;
            8'h26:   return 6'b001000;
            8'h64:   return 6'b010000;
            8'h65:   return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic       rep_q, rep_d;
    logic       repne_q, repne_d;
    logic       size_q, size_d;
    logic       seg_q, seg_d;
    logic [5:0] segsel_q, segsel_d;
    logic [3:0] pcnt_q, pcnt_d;
    logic       perr_q, perr_d;
    logic       dbl_q, dbl_d;
    logic [7:0] b1_q, b1_d;
    logic [7:0] b2_q, b2_d;
    logic [7:0] b3_q, b3_d;

    logic       in_rdy;
    logic       acc;
    logic       handoff;
    logic       pref_mode;
    logic       clr;
    logic [3:0] pcnt_base;
    logic       pref_full;
    logic       take_prefix;
    logic       take_b1;

    // A held packet being accepted turns this cycle into a PREF cycle for the next instruction.
    always_comb begin
        in_rdy      = !flush && ((state_q != HOLD) || bus.out_ready);
        acc         = bus.in_valid && in_rdy;
        handoff     = (state_q == HOLD) && bus.out_ready;
        pref_mode   = (state_q == PREF) || handoff;
        clr         = flush || handoff;
        pcnt_base   = handoff ? 4'd0 : pcnt_q;
        pref_full   = (pcnt_base == MAX_CNT);
        take_prefix = acc && pref_mode && is_prefix(bus.in_byte) && !pref_full;
        take_b1     = acc && pref_mode && !take_prefix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= PREF;
            rep_q    <= 1'b0;
            repne_q  <= 1'b0;
            size_q   <= 1'b0;
            seg_q    <= 1'b0;
            segsel_q <= 6'd0;
            pcnt_q   <= 4'd0;
            perr_q   <= 1'b0;
            dbl_q    <= 1'b0;
            b1_q     <= 8'd0;
            b2_q     <= 8'd0;
            b3_q     <= 8'd0;
        end else begin
            state_q  <= state_d;
            rep_q    <= rep_d;
            repne_q  <= repne_d;
            size_q   <= size_d;
            seg_q    <= seg_d;
            segsel_q <= segsel_d;
            pcnt_q   <= pcnt_d;
            perr_q   <= perr_d;
            dbl_q    <= dbl_d;
            b1_q     <= b1_d;
            b2_q     <= b2_d;
            b3_q     <= b3_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = PREF;
        end else begin
            case (state_q)
                PREF:    if (take_b1) state_d = GET2;
                GET2:    if (acc)     state_d = GET3;
                GET3:    if (acc)     state_d = HOLD;
                HOLD:    if (handoff) state_d = take_b1 ? GET2 : PREF;
                default:              state_d = PREF;
            endcase
        end
    end

    always_comb begin
        rep_d    = clr ? 1'b0 : rep_q;
        repne_d  = clr ? 1'b0 : repne_q;
        size_d   = clr ? 1'b0 : size_q;
        seg_d    = clr ? 1'b0 : seg_q;
        segsel_d = clr ? 6'd0 : segsel_q;
        pcnt_d   = clr ? 4'd0 : pcnt_q;
        perr_d   = clr ? 1'b0 : perr_q;
        dbl_d    = clr ? 1'b0 : dbl_q;
        b1_d     = b1_q;
        b2_d     = b2_q;
        b3_d     = b3_q;

        if (take_prefix) begin
            pcnt_d = pcnt_base + 4'd1;
            case (bus.in_byte)
                8'hF3: begin
                    rep_d   = 1'b1;
                    repne_d = 1'b0;
                end
                8'hF2: begin
                    rep_d   = 1'b1;
                    repne_d = 1'b1;
                end
                8'h66: size_d = 1'b1;
                8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: begin
                    seg_d    = 1'b1;
                    segsel_d = seg_code(bus.in_byte);
                end
                default: ;
            endcase
        end

        if (take_b1) begin
            b1_d   = bus.in_byte;
            dbl_d  = (bus.in_byte == 8'h0F);
            perr_d = pref_full;
        end

        if (acc && (state_q == GET2)) b2_d = bus.in_byte;
        if (acc && (state_q == GET3)) b3_d = bus.in_byte;
    end

    always_comb begin
        bus.in_ready  = in_rdy;
        bus.out_valid = (state_q == HOLD);
        bus.isREP     = rep_q;
        bus.isREPNE   = repne_q;
        bus.isSIZE    = size_q;
        bus.isSEG     = seg_q;
        bus.segSEL    = segsel_q;
        bus.prefSize  = pcnt_q;
        bus.pref_err  = perr_q;
        bus.isDouble  = dbl_q;
        bus.B1        = b1_q;
        bus.B2        = b2_q;
        bus.B3        = b3_q;
    end

endmodule
